// File: rtl/multi_slave_interconnect.sv
// Single-master bus: accepts one valid/ready request, decodes the slave index and
// completes the access after WAIT_CYCLES on a register-bank slave or errors out immediately.
module multi_slave_interconnect #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned SLV_ADDR_W  = 4,
    parameter int unsigned NUM_SLAVES  = 3,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_req_valid,
    output logic              io_req_ready,
    input  logic              io_req_wr,
    input  logic [ADDR_W-1:0] io_req_addr,
    input  logic [DATA_W-1:0] io_req_wdata,
    output logic              io_resp_valid,
    output logic [DATA_W-1:0] io_resp_rdata,
    output logic              io_resp_err,
    output logic [7:0]        io_err_count
);

    localparam int unsigned IDX_W = ADDR_W - SLV_ADDR_W;
    localparam int unsigned DEPTH = 1 << SLV_ADDR_W;
    localparam int unsigned WC_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]            r_state;
    logic [WC_W-1:0]       r_wait;
    logic                  r_wr;
    logic [IDX_W-1:0]      r_slv;
    logic [SLV_ADDR_W-1:0] r_word;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_err;
    logic [7:0]            r_err_count;

    logic                  w_accept;
    logic [IDX_W-1:0]      w_req_idx;
    logic                  w_req_mapped;
    logic                  w_commit;
    logic [DATA_W-1:0]     w_rd_data;
    logic [DATA_W-1:0]     w_bank_rd [NUM_SLAVES];

    assign w_accept     = io_req_valid && (r_state == ST_IDLE);
    assign w_req_idx    = io_req_addr[ADDR_W-1:SLV_ADDR_W];
    // One extra bit so NUM_SLAVES == 2^IDX_W still compares correctly.
    assign w_req_mapped = ({1'b0, w_req_idx} < (IDX_W + 1)'(NUM_SLAVES));
    assign w_commit     = (r_state == ST_ACCESS) && (r_wait == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wait      <= '0;
            r_wr        <= 1'b0;
            r_slv       <= '0;
            r_word      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_wr    <= io_req_wr;
                        r_slv   <= w_req_idx;
                        r_word  <= io_req_addr[SLV_ADDR_W-1:0];
                        r_wdata <= io_req_wdata;
                        r_rdata <= '0;
                        if (w_req_mapped) begin
                            r_state <= ST_ACCESS;
                            r_wait  <= WC_W'(WAIT_CYCLES);
                            r_err   <= 1'b0;
                        end else begin
                            r_state <= ST_RESP;
                            r_err   <= 1'b1;
                            if (r_err_count != 8'hFF) begin
                                r_err_count <= r_err_count + 8'd1;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_wait != '0) begin
                        r_wait <= r_wait - WC_W'(1);
                    end else begin
                        r_state <= ST_RESP;
                        r_rdata <= r_wr ? '0 : w_rd_data;
                        r_err   <= 1'b0;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slave
        localparam logic [IDX_W-1:0] SLV_ID = IDX_W'(g);

        logic [DATA_W-1:0] r_bank [DEPTH];
        logic              w_we;

        assign w_we = w_commit && r_wr && (r_slv == SLV_ID);

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    r_bank[i] <= '0;
                end
            end else if (w_we) begin
                r_bank[r_word] <= r_wdata;
            end
        end

        assign w_bank_rd[g] = r_bank[r_word];
    end

    always_comb begin
        w_rd_data = '0;
        for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
            if (r_slv == IDX_W'(s)) begin
                w_rd_data = w_bank_rd[s];
            end
        end
    end

    assign io_req_ready  = (r_state == ST_IDLE);
    assign io_resp_valid = (r_state == ST_RESP);
    assign io_resp_rdata = io_resp_valid ? r_rdata : '0;
    assign io_resp_err   = io_resp_valid ? r_err : 1'b0;
    assign io_err_count  = r_err_count;

endmodule

// File: tb/tb_multi_slave_interconnect.sv
// Two instances (WAIT_CYCLES=1 and 0) driven by directed and random transactions,
// checked against an array-based memory model with spec-derived latencies.
module tb_multi_slave_interconnect;

    localparam int WAIT_A = 1;
    localparam int WAIT_B = 0;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst   [2];
    logic        vld   [2];
    logic        wr    [2];
    logic [5:0]  addr  [2];
    logic [31:0] wdata [2];
    logic        rdy   [2];
    logic        rv    [2];
    logic        err   [2];
    logic [31:0] rdata [2];
    logic [7:0]  ecnt  [2];

    multi_slave_interconnect #(.DATA_W(32), .ADDR_W(6), .SLV_ADDR_W(4), .NUM_SLAVES(3), .WAIT_CYCLES(WAIT_A)) dut_a (
        .clock(clock), .reset(rst[0]),
        .io_req_valid(vld[0]), .io_req_ready(rdy[0]), .io_req_wr(wr[0]),
        .io_req_addr(addr[0]), .io_req_wdata(wdata[0]),
        .io_resp_valid(rv[0]), .io_resp_rdata(rdata[0]), .io_resp_err(err[0]),
        .io_err_count(ecnt[0])
    );

    multi_slave_interconnect #(.DATA_W(32), .ADDR_W(6), .SLV_ADDR_W(4), .NUM_SLAVES(3), .WAIT_CYCLES(WAIT_B)) dut_b (
        .clock(clock), .reset(rst[1]),
        .io_req_valid(vld[1]), .io_req_ready(rdy[1]), .io_req_wr(wr[1]),
        .io_req_addr(addr[1]), .io_req_wdata(wdata[1]),
        .io_resp_valid(rv[1]), .io_resp_rdata(rdata[1]), .io_resp_err(err[1]),
        .io_err_count(ecnt[1])
    );

    logic [31:0] mdl_mem [2][64];
    int          mdl_ecnt [2];
    int          wait_of  [2];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset(input int d);
        for (int a = 0; a < 64; a++) mdl_mem[d][a] = '0;
        mdl_ecnt[d] = 0;
    endtask

    task automatic check_idle_outputs(input int d);
        check_val("rst_ready", rdy[d], 1);
        check_val("rst_rvalid", rv[d], 0);
        check_val("rst_rdata", rdata[d], 0);
        check_val("rst_err", err[d], 0);
        check_val("rst_ecnt", ecnt[d], 0);
    endtask

    // Called at a negedge; returns at the negedge of the cycle after the response.
    task automatic txn(input int d, input bit w, input logic [5:0] a, input logic [31:0] wd,
                       input bit hold, input bit nw, input logic [5:0] na, input logic [31:0] nwd);
        bit          mapped;
        int          exp_lat;
        logic [31:0] exp_rd;
        int          k;
        bit          seen;
        mapped  = (a[5:4] < 2'd3);
        exp_lat = mapped ? wait_of[d] + 2 : 1;
        exp_rd  = (mapped && !w) ? mdl_mem[d][a] : 32'h0;
        if (mapped && w) mdl_mem[d][a] = wd;
        if (!mapped && mdl_ecnt[d] < 255) mdl_ecnt[d]++;

        check_val("ready_pre", rdy[d], 1);
        vld[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd;
        @(posedge clock);
        #1;
        if (hold) begin
            wr[d] = nw; addr[d] = na; wdata[d] = nwd;
        end else begin
            vld[d] = 1'b0;
            wr[d] = 1'($urandom_range(0, 1));
            addr[d] = 6'($urandom_range(0, 63));
            wdata[d] = $urandom;
        end
        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clock);
            k++;
            check_val("ready_busy", rdy[d], 0);
            if (rv[d]) seen = 1'b1;
            else check_val("quiet_out", {err[d], rdata[d]}, 0);
        end
        if (!seen) begin
            check_val("resp_timeout", 0, 1);
        end else begin
            check_val("latency", k, exp_lat);
            check_val("resp_err", err[d], !mapped);
            check_val("resp_rdata", rdata[d], exp_rd);
            check_val("err_count", ecnt[d], mdl_ecnt[d]);
        end
        @(negedge clock);
        check_val("ready_post", rdy[d], 1);
        check_val("rvalid_post", rv[d], 0);
    endtask

    task automatic simple(input int d, input bit w, input logic [5:0] a, input logic [31:0] wd);
        txn(d, w, a, wd, 1'b0, 1'b0, 6'h0, 32'h0);
    endtask

    initial begin
        wait_of[0] = WAIT_A;
        wait_of[1] = WAIT_B;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; vld[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
            mdl_reset(d);
        end
        repeat (2) @(negedge clock);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clock);
        check_idle_outputs(0);
        check_idle_outputs(1);

        // Basic write/read, independent slaves, decode error
        simple(0, 1, 6'h07, 32'hA);
        simple(0, 0, 6'h07, 32'h0);
        simple(0, 1, 6'h08, 32'hB);
        simple(0, 1, 6'h18, 32'hC);
        simple(0, 0, 6'h08, 32'h0);
        simple(0, 0, 6'h18, 32'h0);
        simple(0, 1, 6'h30, 32'hDEAD);
        simple(0, 0, 6'h00, 32'h0);

        // Valid held high across transactions with inputs changing after accept
        simple(0, 1, 6'h22, 32'h77);
        txn(0, 0, 6'h22, 32'h0, 1'b1, 1'b1, 6'h13, 32'h99);
        txn(0, 1, 6'h13, 32'h99, 1'b1, 1'b0, 6'h13, 32'h0);
        simple(0, 0, 6'h13, 32'h0);

        // Reset landing on the commit edge of a write
        simple(0, 1, 6'h05, 32'h11);
        vld[0] = 1'b1; wr[0] = 1'b1; addr[0] = 6'h05; wdata[0] = 32'h55;
        @(posedge clock);
        #1 vld[0] = 1'b0;
        @(negedge clock);
        @(negedge clock);
        rst[0] = 1'b1;
        @(negedge clock);
        rst[0] = 1'b0;
        mdl_reset(0);
        check_idle_outputs(0);
        @(negedge clock);
        check_val("rst_no_resp", rv[0], 0);
        simple(0, 0, 6'h05, 32'h0);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            simple(0, 1'($urandom_range(0, 1)), {2'b11, 4'($urandom_range(0, 15))}, $urandom);
        end
        check_val("ecnt_sat", ecnt[0], 255);

        // Zero-wait instance
        simple(1, 1, 6'h2F, 32'hCAFE0001);
        simple(1, 0, 6'h2F, 32'h0);
        simple(1, 1, 6'h3A, 32'h1);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 150; i++) begin
                simple(d, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
